rv16_fetch_aligner: RTL and testbench
=====================================

// Module: rv16_fetch_aligner
// PURPOSE
//  Instruction fetch/align unit feeding rv16_decoder's i_instruction/i_is_compressed inputs.
//  Fetches 32-bit words from instruction memory and buffers them as halfwords.
//  Extracts 16-bit (RVC, bits[1:0]!=2'b11) and 32-bit instructions, including 32-bit ones
//  that straddle word boundaries. Presents one instruction per cycle with its PC.
//  Flushes and restarts on a branch/jump redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched after reset; bit0 ignored.
//  BUF_HW    4              halfword buffer depth; legal values 4..8, even.
// PORTS
//  i_clk             in   1   clock; all state updates on the rising edge.
//  i_rst             in   1   asynchronous, active-high reset.
//  i_redirect        in   1   flush and restart fetch at i_redirect_pc.
//  i_redirect_pc     in   32  new PC, halfword aligned; bit0 ignored.
//  o_imem_req        out  1   memory read request.
//  o_imem_addr       out  32  word address; [1:0]=2'b00.
//  i_imem_gnt        in   1   request accepted this cycle (when o_imem_req=1).
//  i_imem_rvalid     in   1   read data valid.
//  i_imem_rdata      in   32  read data, little-endian halfwords.
//  o_instr_valid     out  1   o_instruction/o_pc valid.
//  i_instr_ready     in   1   consumer accepts the instruction.
//  o_instruction     out  32  instruction; RVC is zero-extended {16'h0,hw}.
//  o_is_compressed   out  1   1 = 16-bit instruction.
//  o_pc              out  32  address of o_instruction.
// BEHAVIOUR
//  Reset: buffer empty, fetch PC=RESET_PC, state IDLE, drop flag=0.
//    o_imem_req=0, o_imem_addr=0, o_instr_valid=0, o_instruction=0, o_is_compressed=0,
//    o_pc=RESET_PC.
//  Fetch FSM (one outstanding request max):
//    IDLE->REQ when free slots (registered count) >=2 and no redirect.
//    REQ: o_imem_req=1, o_imem_addr={fpc[31:2],2'b00} held stable; ->WAIT on i_imem_gnt.
//    WAIT: on i_imem_rvalid push halfwords, fpc=word+4, ->IDLE.
//    Push both halfwords normally. Push only rdata[31:16] if fpc[1]=1 (first fetch after
//    odd-halfword redirect).
//    i_imem_rvalid outside WAIT is ignored.
//  Output (combinational from registered buffer, BUF_HW entries, count 0..BUF_HW):
//    hw0[1:0]!=11 & count>=1 -> valid, compressed, instr={16'h0,hw0}.
//    hw0[1:0]==11 & count>=2 -> valid, instr={hw1,hw0}.
//    Otherwise o_instr_valid=0 and o_instruction=0.
//    o_instruction/o_pc stable while valid & !ready.
//  Consume on valid&ready: pop 1 (RVC) or 2 halfwords; o_pc += 2 or 4 (mod 2^32 wrap).
//  Push and pop in the same cycle are both applied; count never exceeds BUF_HW.
//  Redirect (highest priority, same-cycle effect at next edge):
//    Buffer cleared; o_pc and fpc = i_redirect_pc & ~1; pop that cycle discarded.
//    In REQ: request withdrawn (req=0 next cycle), FSM->IDLE.
//    In WAIT: drop flag set, FSM stays WAIT; the next rvalid is discarded, flag clears,
//      ->IDLE.
//    Redirect coincident with rvalid: that data is discarded.
//  Steady state: latency from rvalid to o_instr_valid = 1 cycle (registered buffer).
//  Reset mid-operation: all state returns to reset values immediately.
// TESTING
//  1. Reset, RESET_PC=0, mem[0]=32'h0000_0013 -> addr 0x0 requested; valid, instr=0x00000013,
//     compressed=0, pc=0; next req addr 0x4.
//  2. mem[0]=32'h4501_4085 -> instr 0x00004085 pc=0 compressed, then 0x00004501 pc=2;
//     ready held 1.
//  3. Straddle: mem[0]=32'h0513_4501, mem[4]=32'h4085_0000 -> 0x4501@0 (C),
//     0x00000513@2 (32-bit), 0x4085@6 (C).
//  4. Redirect to 0x102 while in WAIT -> stale rvalid dropped; next addr 0x100; first
//     output pc=0x102 from rdata[31:16].
//  5. i_instr_ready=0 for 20 cycles, all RVC -> requests stop at count=BUF_HW; output
//     stable; no halfword lost or duplicated after release.
//  6. i_rst pulse during WAIT, then late rvalid -> ignored; fetch restarts at RESET_PC;
//     o_instr_valid=0 until then.

Source files
------------

// File: rtl/rv16_fetch_aligner.sv
// Purpose: fetch 32-bit words, buffer halfwords, and present aligned RVC/32-bit instructions with their PC.
// Latency: rvalid to o_instr_valid is one cycle; at most one memory request is in flight.
// Backpressure: outputs hold while i_instr_ready is low, and fetch stalls until the buffer has two free halfword slots.
module rv16_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instruction,
  output logic        o_is_compressed,
  output logic [31:0] o_pc
);

  localparam int CW = $clog2(BUF_HW + 1);
  typedef logic [CW-1:0] cnt_t;

  // A fetch is only launched when a full word is guaranteed to fit.
  localparam cnt_t REQ_MAX = cnt_t'(BUF_HW - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  logic [15:0] hw_q [BUF_HW];
  logic [15:0] hw_d [BUF_HW];

  logic        is_wide;
  logic        instr_vld;
  cnt_t        push_n;
  cnt_t        pop_n;
  cnt_t        base;
  logic [15:0] push0;
  logic [15:0] push1;

  // fpc bit 0 is always zero; only bit 1 and the word address are consumed.
  logic unused_fpc0;
  assign unused_fpc0 = fpc_q[0];

  // Decode the head of the buffer into the presented instruction.
  always_comb begin
    is_wide         = (hw_q[0][1:0] == 2'b11);
    instr_vld       = is_wide ? (cnt_q >= cnt_t'(2)) : (cnt_q >= cnt_t'(1));
    o_instr_valid   = instr_vld;
    o_is_compressed = instr_vld & ~is_wide;
    o_instruction   = '0;
    if (instr_vld) begin
      o_instruction = is_wide ? {hw_q[1], hw_q[0]} : {16'h0000, hw_q[0]};
    end
    o_pc        = pc_q;
    o_imem_req  = (state_q == ST_REQ);
    o_imem_addr = (state_q == ST_REQ) ? {fpc_q[31:2], 2'b00} : 32'h0;
  end

  // Fetch FSM: request sequencing, redirect handling and halfword push selection.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    drop_d  = drop_q;
    push_n  = '0;
    push0   = fpc_q[1] ? i_imem_rdata[31:16] : i_imem_rdata[15:0];
    push1   = i_imem_rdata[31:16];
    case (state_q)
      ST_IDLE: begin
        if (!i_redirect && (cnt_q <= REQ_MAX)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_redirect) begin
          // A grant in the redirect cycle still produces a response; wait for it and discard it
          // so it cannot be mistaken for the reply to the next request.
          state_d = i_imem_gnt ? ST_WAIT : ST_IDLE;
          drop_d  = i_imem_gnt;
        end else if (i_imem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !i_redirect) begin
            push_n = fpc_q[1] ? cnt_t'(1) : cnt_t'(2);
            fpc_d  = {fpc_q[31:2], 2'b00} + 32'd4;
          end
        end else if (i_redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_redirect) begin
      fpc_d = i_redirect_pc & ~32'h1;
    end
  end

  // Buffer update: pop from the head, then append fresh halfwords behind the survivors.
  always_comb begin
    pop_n = '0;
    if (instr_vld && i_instr_ready && !i_redirect) begin
      pop_n = is_wide ? cnt_t'(2) : cnt_t'(1);
    end
    pc_d = pc_q;
    if (i_redirect) begin
      pc_d = i_redirect_pc & ~32'h1;
    end else if (pop_n != '0) begin
      pc_d = pc_q + (is_wide ? 32'd4 : 32'd2);
    end

    hw_d = hw_q;
    if (pop_n == cnt_t'(1)) begin
      for (int i = 0; i < BUF_HW - 1; i++) hw_d[i] = hw_q[i+1];
    end else if (pop_n == cnt_t'(2)) begin
      for (int i = 0; i < BUF_HW - 2; i++) hw_d[i] = hw_q[i+2];
    end

    base = cnt_q - pop_n;
    for (int i = 0; i < BUF_HW; i++) begin
      if ((push_n >= cnt_t'(1)) && (cnt_t'(i) == base)) hw_d[i] = push0;
      if ((push_n == cnt_t'(2)) && (cnt_t'(i) == base + cnt_t'(1))) hw_d[i] = push1;
    end

    cnt_d = i_redirect ? '0 : base + push_n;
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC & ~32'h1;
      pc_q    <= RESET_PC & ~32'h1;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < BUF_HW; i++) hw_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      hw_q    <= hw_d;
    end
  end

endmodule

// File: tb/tb_rv16_fetch_aligner.sv
// Purpose: directed stimulus for rv16_fetch_aligner with an instruction-stream model and memory responder.
// Latency: memory answers a grant after a programmable number of cycles.
// Backpressure: the consumer ready is driven per test; outputs are compared on every falling edge.
module tb_rv16_fetch_aligner;

  localparam int          BUF_HW   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic [31:0] o_instruction;
  logic        o_is_compressed;
  logic [31:0] o_pc;

  logic        gnt_en = 1'b0;
  assign i_imem_gnt = o_imem_req & gnt_en;

  always #5 i_clk = ~i_clk;

  rv16_fetch_aligner #(.RESET_PC(RESET_PC), .BUF_HW(BUF_HW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .o_instruction(o_instruction), .o_is_compressed(o_is_compressed), .o_pc(o_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [128];
  logic [31:0] gnt_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cons_cnt = 0;
  int          lat = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected instruction stream: walk memory halfword by halfword from the start PC.
  task automatic build(input logic [31:0] start);
    logic [31:0] pc;
    logic [15:0] h;
    exp_t        e;
    exp_q.delete();
    pc = start & ~32'h1;
    for (int k = 0; k < 200; k++) begin
      h    = hw_at(pc);
      e.pc = pc;
      if (h[1:0] == 2'b11) begin
        e.instr = {hw_at(pc + 32'd2), h};
        e.comp  = 1'b0;
        pc      = pc + 32'd4;
      end else begin
        e.instr = {16'h0000, h};
        e.comp  = 1'b1;
        pc      = pc + 32'd2;
      end
      exp_q.push_back(e);
    end
    cons_cnt = 0;
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 128; k++) mem[k] = 32'h0;
  endtask

  // Every halfword is a distinct compressed encoding derived from its own address.
  task automatic fill_pattern();
    logic [13:0] i0;
    logic [13:0] i1;
    for (int k = 0; k < 128; k++) begin
      i0 = 14'(2 * k);
      i1 = 14'(2 * k + 1);
      mem[k] = {i1, 2'b01, i0, 2'b01};
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic assert_reset();
    step();
    i_rst      = 1'b1;
    gnt_en     = 1'b0;
    i_redirect = 1'b0;
  endtask

  task automatic release_reset();
    repeat (8) step();
    chk("rst_req", {31'h0, o_imem_req}, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_valid", {31'h0, o_instr_valid}, 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_comp", {31'h0, o_is_compressed}, 32'h0);
    chk("rst_pc", o_pc, RESET_PC);
    build(RESET_PC);
    gnt_log.delete();
    i_rst  = 1'b0;
    gnt_en = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_valid: no valid instruction within %0d cycles", budget);
    end
  endtask

  task automatic expect_consumed(input string name, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (cons_cnt >= n) break;
    end
    chk(name, {31'h0, (cons_cnt >= n)}, 32'h1);
  endtask

  // Memory responder: one outstanding read, data returned lat cycles after the grant.
  initial begin
    forever begin
      @(negedge i_clk);
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'hDEAD_BEEF;
      if (pend) begin
        if (pend_cnt == 0) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem[pend_addr[8:2]];
          pend          = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (o_imem_req && gnt_en) begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = o_imem_addr;
        gnt_log.push_back(o_imem_addr);
      end
    end
  end

  // Stream compare: every presented instruction must match the model head; a handshake pops it.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_instr_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stream_extra: got pc %h, required no instruction", o_pc);
        end else begin
          chk("stream_pc", o_pc, exp_q[0].pc);
          chk("stream_instr", o_instruction, exp_q[0].instr);
          chk("stream_comp", {31'h0, o_is_compressed}, {31'h0, exp_q[0].comp});
          if (i_instr_ready) begin
            void'(exp_q.pop_front());
            cons_cnt++;
          end
        end
      end else begin
        chk("idle_instr_zero", o_instruction, 32'h0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_zero();

    // 1: single 32-bit instruction at the reset PC.
    assert_reset();
    fill_zero();
    mem[0] = 32'h0000_0013;
    release_reset();
    chk("t1_model_instr", exp_q[0].instr, 32'h0000_0013);
    chk("t1_model_comp", {31'h0, exp_q[0].comp}, 32'h0);
    i_instr_ready = 1'b1;
    wait_valid(20, ok);
    if (ok) begin
      chk("t1_instr", o_instruction, 32'h0000_0013);
      chk("t1_pc", o_pc, 32'h0);
      chk("t1_comp", {31'h0, o_is_compressed}, 32'h0);
    end
    repeat (10) step();
    chk("t1_gnt_count", {31'h0, (gnt_log.size() >= 2)}, 32'h1);
    if (gnt_log.size() >= 2) begin
      chk("t1_addr0", gnt_log[0], 32'h0);
      chk("t1_addr1", gnt_log[1], 32'h4);
    end

    // 2: two compressed instructions in one word.
    assert_reset();
    fill_zero();
    mem[0] = 32'h4501_4085;
    release_reset();
    chk("t2_model_i0", exp_q[0].instr, 32'h0000_4085);
    chk("t2_model_c0", {31'h0, exp_q[0].comp}, 32'h1);
    chk("t2_model_pc1", exp_q[1].pc, 32'h2);
    chk("t2_model_i1", exp_q[1].instr, 32'h0000_4501);
    expect_consumed("t2_consumed", 2, 30);

    // 3: 32-bit instruction straddling a word boundary.
    assert_reset();
    fill_zero();
    mem[0] = 32'h0513_4501;
    mem[1] = 32'h4085_0000;
    lat    = 1;
    release_reset();
    chk("t3_model_i0", exp_q[0].instr, 32'h0000_4501);
    chk("t3_model_pc1", exp_q[1].pc, 32'h2);
    chk("t3_model_i1", exp_q[1].instr, 32'h0000_0513);
    chk("t3_model_c1", {31'h0, exp_q[1].comp}, 32'h0);
    chk("t3_model_pc2", exp_q[2].pc, 32'h6);
    chk("t3_model_i2", exp_q[2].instr, 32'h0000_4085);
    expect_consumed("t3_consumed", 3, 40);

    // 4: redirect to an odd halfword while a read is outstanding.
    assert_reset();
    fill_pattern();
    lat = 3;
    release_reset();
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (pend) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_in_wait", {31'h0, ok}, 32'h1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0102;
    step();
    i_redirect = 1'b0;
    build(32'h0000_0102);
    gnt_log.delete();
    wait_valid(40, ok);
    if (ok) begin
      chk("t4_pc", o_pc, 32'h0000_0102);
      chk("t4_instr", o_instruction, 32'h0000_0205);
      chk("t4_comp", {31'h0, o_is_compressed}, 32'h1);
    end
    chk("t4_gnt_seen", {31'h0, (gnt_log.size() >= 1)}, 32'h1);
    if (gnt_log.size() >= 1) chk("t4_addr", gnt_log[0], 32'h0000_0100);
    expect_consumed("t4_consumed", 6, 60);

    // 5: consumer stalled for 20 cycles; fetch must stop once the buffer is full.
    lat = 1;
    step();
    i_instr_ready = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0001;
    step();
    i_redirect = 1'b0;
    build(32'h0);
    gnt_log.delete();
    repeat (20) step();
    chk("t5_gnt_count", 32'(gnt_log.size()), 32'(BUF_HW / 2));
    chk("t5_req_stopped", {31'h0, o_imem_req}, 32'h0);
    chk("t5_valid_held", {31'h0, o_instr_valid}, 32'h1);
    chk("t5_pc_held", o_pc, 32'h0);
    chk("t5_instr_held", o_instruction, 32'h0000_0001);
    i_instr_ready = 1'b1;
    expect_consumed("t5_consumed", 12, 80);

    // 6: reset pulse during a read; the late response must be ignored.
    lat = 5;
    step();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0040;
    step();
    i_redirect = 1'b0;
    build(32'h0000_0040);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (pend && (pend_addr == 32'h0000_0040)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_in_wait", {31'h0, ok}, 32'h1);
    i_rst  = 1'b1;
    gnt_en = 1'b0;
    build(RESET_PC);
    step();
    chk("t6_rst_req", {31'h0, o_imem_req}, 32'h0);
    chk("t6_rst_valid", {31'h0, o_instr_valid}, 32'h0);
    chk("t6_rst_pc", o_pc, RESET_PC);
    i_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t6_no_valid", {31'h0, o_instr_valid}, 32'h0);
    end
    chk("t6_restart_req", {31'h0, o_imem_req}, 32'h1);
    chk("t6_restart_addr", o_imem_addr, RESET_PC);
    gnt_log.delete();
    gnt_en = 1'b1;
    expect_consumed("t6_consumed", 4, 60);
    chk("t6_gnt_seen", {31'h0, (gnt_log.size() >= 1)}, 32'h1);
    if (gnt_log.size() >= 1) chk("t6_addr", gnt_log[0], RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
